// File: rtl/serial_to_parallel_rx.sv
// Receive-side deserializer for one PCIe lane: finds byte alignment by locking
// onto repeated COM symbols, then presents each aligned byte with a payload flag.
module serial_to_parallel_rx #(
  parameter logic [7:0]  COM        = 8'hBC,
  parameter logic [7:0]  IDL        = 8'h7C,
  parameter int unsigned LOCK_COUNT = 4
) (
  input  logic       clk_8f,
  input  logic       reset_L,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active
);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    LOCKING = 2'd1,
    ACTIVE  = 2'd2
  } state_t;

  localparam logic [3:0] LOCK_CNT = 4'(LOCK_COUNT);

  state_t     state_q,   state_d;
  logic [7:0] sr_q,      sr_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] com_cnt_q, com_cnt_d;
  logic [7:0] data_q,    data_d;
  logic       valid_q,   valid_d;
  logic       active_q,  active_d;

  logic [7:0] cand;
  logic       cand_is_com;
  logic       boundary;
  logic [3:0] com_cnt_inc;

  assign cand        = {sr_q[6:0], data_in};
  assign cand_is_com = (cand == COM);
  assign boundary    = (bit_cnt_q == 3'd7);
  assign com_cnt_inc = com_cnt_q + 4'd1;

  always_comb begin
    state_d   = state_q;
    sr_d      = cand;
    bit_cnt_d = bit_cnt_q;
    com_cnt_d = com_cnt_q;
    data_d    = data_q;
    valid_d   = valid_q;
    active_d  = active_q;

    case (state_q)
      SEARCH: begin
        if (cand_is_com) begin
          bit_cnt_d = 3'd0;
          com_cnt_d = 4'd1;
          state_d   = LOCKING;
        end
      end

      LOCKING: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        // Only boundary-aligned COMs count; any other boundary byte restarts the hunt.
        if (boundary) begin
          if (cand_is_com) begin
            com_cnt_d = com_cnt_inc;
            if (com_cnt_inc == LOCK_CNT) begin
              state_d  = ACTIVE;
              active_d = 1'b1;
            end
          end else begin
            com_cnt_d = 4'd0;
            state_d   = SEARCH;
          end
        end
      end

      ACTIVE: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (boundary) begin
          data_d  = cand;
          valid_d = (cand != COM) && (cand != IDL);
        end
      end

      default: begin
        state_d   = SEARCH;
        com_cnt_d = 4'd0;
        active_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_8f or negedge reset_L) begin
    if (!reset_L) begin
      state_q   <= SEARCH;
      sr_q      <= 8'h00;
      bit_cnt_q <= 3'd0;
      com_cnt_q <= 4'd0;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      com_cnt_q <= com_cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      active_q  <= active_d;
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign active    = active_q;

endmodule

// File: tb/tb_serial_to_parallel_rx.sv
// Self-checking bench for serial_to_parallel_rx: directed scenarios plus random
// streams, all scored against a stream-scanning reference model.
module tb_serial_to_parallel_rx;

  localparam logic [7:0] COM        = 8'hBC;
  localparam logic [7:0] IDL        = 8'h7C;
  localparam int         LOCK_COUNT = 4;

  logic       clk_8f;
  logic       reset_L;
  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;

  int total;
  int bad;

  logic       bit_q[$];
  logic [9:0] obs_q[$];

  serial_to_parallel_rx #(
    .COM(COM),
    .IDL(IDL),
    .LOCK_COUNT(LOCK_COUNT)
  ) dut (
    .clk_8f(clk_8f),
    .reset_L(reset_L),
    .data_in(data_in),
    .data_out(data_out),
    .valid_out(valid_out),
    .active(active)
  );

  initial clk_8f = 1'b0;
  always #5 clk_8f = ~clk_8f;

  task automatic checkOutput(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Byte ending at stream index i; bits before the stream start read as zero.
  function automatic logic [7:0] byte_at(int i);
    logic [7:0] r;
    int idx;
    r = 8'h00;
    for (int k = 0; k < 8; k++) begin
      idx = i - 7 + k;
      r = {r[6:0], (idx >= 0) ? bit_q[idx] : 1'b0};
    end
    return r;
  endfunction

  // Scans the stream for the first COM at any offset, then demands LOCK_COUNT-1
  // further COMs every 8 bits; on a miss the scan resumes just past that byte.
  function automatic int find_lock();
    int i;
    int n;
    int j;
    bit ok;
    i = 0;
    n = bit_q.size();
    while (i < n) begin
      if (byte_at(i) == COM) begin
        ok = 1'b1;
        for (int m = 1; m < LOCK_COUNT; m++) begin
          j = i + 8 * m;
          if (j >= n) return -1;
          if (byte_at(j) != COM) begin
            ok = 1'b0;
            i = j + 1;
            break;
          end
        end
        if (ok) return i + 8 * (LOCK_COUNT - 1);
      end else begin
        i++;
      end
    end
    return -1;
  endfunction

  function automatic logic [9:0] expected_at(int k, int lock);
    logic [7:0] d;
    logic       v;
    logic       a;
    int         j;
    d = 8'h00;
    v = 1'b0;
    a = 1'b0;
    if (lock >= 0 && k >= lock) a = 1'b1;
    if (lock >= 0 && k >= lock + 8) begin
      j = lock + ((k - lock) / 8) * 8;
      d = byte_at(j);
      v = (d != COM) && (d != IDL);
    end
    return {a, v, d};
  endfunction

  // Every stimulus task is entered and left at a falling edge.
  task automatic send_bit(input logic b);
    data_in = b;
    @(posedge clk_8f);
    #1;
    bit_q.push_back(b);
    obs_q.push_back({active, valid_out, data_out});
    @(negedge clk_8f);
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    for (int k = 7; k >= 0; k--) send_bit(b[k]);
  endtask

  task automatic start_scenario();
    @(negedge clk_8f);
    reset_L = 1'b0;
    data_in = 1'b0;
    repeat (2) @(negedge clk_8f);
    checkOutput("reset_state", {active, valid_out, data_out}, 0);
    reset_L = 1'b1;
    bit_q.delete();
    obs_q.delete();
  endtask

  task automatic check_scenario(input string tag);
    int lock;
    lock = find_lock();
    for (int k = 0; k < obs_q.size(); k++)
      checkOutput($sformatf("%s[%0d]", tag, k), obs_q[k], expected_at(k, lock));
  endtask

  task automatic random_scenario();
    int nbytes;
    int kind;
    start_scenario();
    repeat ($urandom_range(0, 7)) send_bit(1'($urandom));
    nbytes = $urandom_range(12, 24);
    for (int n = 0; n < nbytes; n++) begin
      kind = $urandom_range(0, 9);
      if (kind < 3)       repeat ($urandom_range(1, 5)) applyStimulus(COM);
      else if (kind == 3) applyStimulus(IDL);
      else if (kind == 4) send_bit(1'($urandom));
      else                applyStimulus(8'($urandom));
    end
    check_scenario("rand");
  endtask

  initial begin
    int idx;
    total   = 0;
    bad     = 0;
    reset_L = 1'b0;
    data_in = 1'b0;

    // Aligned lock followed by payload, IDL, COM and back-to-back payload.
    start_scenario();
    repeat (4) applyStimulus(COM);
    applyStimulus(8'hA5);
    applyStimulus(8'h3C);
    applyStimulus(IDL);
    applyStimulus(COM);
    applyStimulus(8'hFF);
    checkOutput("t1_pre_lock", obs_q[30], 10'h000);
    checkOutput("t1_lock",     obs_q[31], 10'h200);
    checkOutput("t2_a5",       obs_q[39], 10'h3A5);
    checkOutput("t2_a5_hold",  obs_q[46], 10'h3A5);
    checkOutput("t2_3c",       obs_q[47], 10'h33C);
    checkOutput("t2_idl",      obs_q[55], 10'h27C);
    checkOutput("t2_com",      obs_q[63], 10'h2BC);
    checkOutput("t2_ff",       obs_q[71], 10'h3FF);
    check_scenario("t12");

    // Lock found at a 3-bit offset.
    start_scenario();
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    repeat (4) applyStimulus(COM);
    applyStimulus(8'h12);
    checkOutput("t3_before", obs_q[41], 10'h200);
    checkOutput("t3_byte",   obs_q[42], 10'h312);
    check_scenario("t3");

    // A non-COM after three COMs discards the partial lock.
    start_scenario();
    repeat (3) applyStimulus(COM);
    applyStimulus(8'h55);
    repeat (4) applyStimulus(COM);
    applyStimulus(8'h99);
    checkOutput("t4_no_lock", obs_q[31], 10'h000);
    checkOutput("t4_byte",    obs_q[71], 10'h399);
    check_scenario("t4");

    // Reset mid-byte after lock, then a fresh lock is required.
    start_scenario();
    repeat (4) applyStimulus(COM);
    applyStimulus(8'hC3);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    checkOutput("t5_c3", obs_q[43], 10'h3C3);
    check_scenario("t5a");
    reset_L = 1'b0;
    #1;
    checkOutput("t5_async_rst", {active, valid_out, data_out}, 0);
    start_scenario();
    applyStimulus(8'hC3);
    repeat (3) applyStimulus(COM);
    applyStimulus(8'h12);
    idx = obs_q.size() - 1;
    checkOutput("t5_relock_none", obs_q[idx], 10'h000);
    repeat (4) applyStimulus(COM);
    applyStimulus(8'h12);
    idx = obs_q.size() - 1;
    checkOutput("t5_relock", obs_q[idx], 10'h312);
    check_scenario("t5b");

    // Misaligned COM inside 5E 00 starts a lock that the next boundary breaks.
    start_scenario();
    applyStimulus(8'h5E);
    applyStimulus(8'h00);
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    applyStimulus(8'h33);
    idx = obs_q.size() - 1;
    checkOutput("t6_inactive", obs_q[idx], 10'h000);
    check_scenario("t6");

    repeat (10) random_scenario();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_to_parallel_rx.md
Name: serial_to_parallel_rx

Overview:
Receive-side deserializer for one PCIe PHY lane. It consumes the serial bitstream produced by the lane's parallel-to-serial transmitter on the bit clock clk_8f. It locates byte boundaries by locking onto repeated COM symbols, then presents assembled bytes to the byte unstriping stage. Idle (IDL) and COM symbols are dropped as non-valid.

Parameters:
COM, 8'hBC, comma symbol used for alignment
IDL, 8'h7C, idle symbol, never flagged valid
LOCK_COUNT, 4, consecutive boundary-aligned COMs required to enter ACTIVE (range 2..15)

Ports:
clk_8f  input  1  bit clock, 8x the byte clock; all logic is on its rising edge
reset_L  input  1  asynchronous, active-low reset
data_in  input  1  serial bit, MSB of each byte first
data_out  output  8  last assembled byte
valid_out  output  1  data_out holds a payload byte (not COM, not IDL)
active  output  1  byte alignment is locked

Behaviour:
- Interface: one clock (clk_8f); reset_L is asynchronous and active-low. Assertion immediately clears all state; release is sampled on the next clk_8f rising edge.
- Reset values:
  - data_out = 8'h00, valid_out = 0, active = 0
  - internal shift register sr = 8'h00, bit_cnt = 0, com_cnt = 0, state = SEARCH
- Shift: on every clock, sr <= {sr[6:0], data_in}. Define cand = {sr[6:0], data_in}, the byte including the current bit.
- SEARCH (active = 0):
  - Compare cand to COM on every clock, at every bit offset.
  - On a match: bit_cnt <= 0, com_cnt <= 1, go to LOCKING.
- LOCKING (active = 0):
  - bit_cnt increments modulo 8. A boundary is a clock where bit_cnt == 7, i.e. the 8th bit after the previous boundary.
  - At a boundary with cand == COM: com_cnt++. If the new com_cnt == LOCK_COUNT, go to ACTIVE and set active <= 1 on the same edge.
  - At a boundary with cand != COM: com_cnt <= 0, go to SEARCH. Do not re-check this same cand for COM; the search resumes on the next clock.
- ACTIVE (active = 1):
  - bit_cnt continues modulo 8.
  - At each boundary: data_out <= cand, and valid_out <= (cand != COM && cand != IDL).
  - data_out and valid_out hold for exactly 8 clk_8f cycles, until the next boundary.
  - ACTIVE is left only by reset. Alignment loss is not detected.
- Outputs outside ACTIVE: data_out and valid_out are not updated; they keep their reset values until the first ACTIVE boundary.
- Latency:
  - The last bit of a byte is sampled at edge N; data_out/valid_out reflect that byte after edge N.
  - The first byte after lock is the byte starting at the bit following the LOCK_COUNT-th COM.
- Boundary conditions:
  - A COM pattern straddling a misaligned offset during LOCKING is ignored; only boundary bytes count.
  - A non-COM byte at a boundary resets com_cnt to 0, even if com_cnt == LOCK_COUNT-1.
  - Consecutive payload bytes each produce valid_out = 1 with no gap.
  - Reset asserted mid-byte or mid-lock: all state returns to reset values asynchronously. After release, a fresh LOCK_COUNT COMs are required.
- No arithmetic beyond the counters. bit_cnt is 3 bits and wraps 7 -> 0; com_cnt is 4 bits and saturates at LOCK_COUNT.

Test Plan:
1. Reset then stream 4x 8'hBC, MSB first, aligned -> active rises on the edge sampling the last bit of the 4th BC; data_out = 8'h00, valid_out = 0 before that edge.
2. After lock, send 8'hA5, 8'h3C, 8'h7C, 8'hBC, 8'hFF -> data_out = A5/3C/7C/BC/FF, each held 8 cycles; valid_out = 1,1,0,0,1.
3. Prefix 3 random bits (101), then 4x BC, then 8'h12 -> lock is achieved despite the offset; data_out = 8'h12 with valid_out = 1 on its 8th bit.
4. Send 3x BC, then 8'h55, then 4x BC, then 8'h99 -> active stays 0 through the 8'h55 and rises only after the second BC group; data_out = 8'h99, valid_out = 1.
5. Lock, send 8'hC3, then pull reset_L low at bit 4 of the next byte -> all outputs 0 immediately; after release, 8'hC3 alone produces no valid_out until 4 new BCs are seen.
6. Stream 8'h5E 8'h00 (the bits contain BC at a non-boundary offset after SEARCH has locked elsewhere), then non-COM boundary bytes -> the state returns to SEARCH and active remains 0.
